mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Consumer end of the EX/MEM pipeline register. Decodes the 7-bit EX/MEM control word,
//  resolves branch/jump and drives redirect + flush. Runs the data-memory req/ack handshake
//  and stalls the pipe until the access ends. Registers the results into the MEM/WB register.
// PARAMETERS
//  DATA_W       32  data/address width
//  ACK_TIMEOUT  16  max WAIT cycles before abandoning the access (must be >= 2)
// PORTS
//  clk_i          in   1       clock, all state on posedge
//  rst_i          in   1       synchronous, active-high reset
//  ctrl_signal_i  in   7       EX/MEM control word; all-zero = bubble
//  pc_branch_i    in   DATA_W  branch target
//  pc_jump_i      in   DATA_W  jump target
//  zero_i         in   1       ALU zero flag
//  retAlu_i       in   DATA_W  ALU result / memory address
//  Wridata_i      in   DATA_W  store data
//  WBaddr_i       in   5       destination register
//  dmem_req_o     out  1       memory request
//  dmem_we_o      out  1       1 = store, 0 = load
//  dmem_addr_o    out  DATA_W  memory address
//  dmem_wdata_o   out  DATA_W  store data to memory
//  dmem_ack_i     in   1       memory done; read data valid this cycle
//  dmem_rdata_i   in   DATA_W  load data
//  mem_stall_o    out  1       freeze PC, IF/ID, ID/EX, EX/MEM
//  pc_src_o       out  2       00 seq, 01 branch, 10 jump
//  pc_target_o    out  DATA_W  redirect target
//  flush_o        out  1       squash younger stages (drives EX2MEM_write low)
//  mem_err_o      out  1       sticky timeout flag
//  RegWrite_o     out  1       MEM/WB: write enable to the register file
//  MemtoReg_o     out  1       MEM/WB: 1 = select memData_o
//  memData_o      out  DATA_W  MEM/WB: load data
//  aluData_o      out  DATA_W  MEM/WB: ALU result
//  WBaddr_o       out  5       MEM/WB: destination register
// BEHAVIOUR
//  - Ctrl bits: [6]RegWrite [5]MemtoReg [4]Branch [3]BranchNe [2]MemRead [1]MemWrite [0]Jump.
//  - Reset: FSM=IDLE, timeout counter=0, mem_err_o=0, all MEM/WB outputs=0.
//    While rst_i=1, dmem_req_o, mem_stall_o, flush_o=0 and pc_src_o=00.
//  - FSM IDLE: acc = MemRead|MemWrite.
//    - acc=1: dmem_req_o=1 combinationally; addr/wdata/we come straight from the inputs.
//    - acc=1 and ack=1 in the same cycle: access done, zero-wait, no stall.
//    - acc=1 and ack=0: latch addr/wdata/we/ctrl/WBaddr/ALU result, go to WAIT,
//      mem_stall_o=1 in that same cycle.
//  - FSM WAIT: dmem_req_o=1 from the latched copies, mem_stall_o=1, counter increments.
//    - ack=1: load MEM/WB from the latch plus rdata, go to IDLE, stall drops that cycle.
//    - counter reaches ACK_TIMEOUT-1 with no ack: set mem_err_o, load a bubble, go to IDLE.
//      A later stray ack is ignored.
//  - MEM/WB register:
//    - Loads the live or latched values when an access completes or none is needed.
//    - Loads a bubble (RegWrite=0) every cycle mem_stall_o=1, so writeback never repeats.
//    - memData_o takes dmem_rdata_i only on a load ack; otherwise it holds its value.
//    - Latency is 1 clock from EX/MEM to MEM/WB, plus the number of wait cycles.
//  - Redirect (combinational, IDLE only, suppressed while mem_stall_o=1):
//    - Jump gives pc_src=10 and target pc_jump_i.
//    - (Branch&zero)|(BranchNe&~zero) gives pc_src=01 and target pc_branch_i.
//    - Jump wins over branch. flush_o = (pc_src_o != 00).
//    - A branch in WAIT is impossible: a word is either a memory op or a branch/jump.
//  - Store: RegWrite is expected 0. A load with WBaddr=0 still completes; the register
//    file ignores r0.
//  - Reset during WAIT: drop req next cycle, discard the latched op, no writeback.
// STRUCTURE
//  - mips_pkg: ctrl bit index localparams, pc_src encodings, bubble constant 7'b0.
//  - Sub-module mem_access_fsm: IDLE/WAIT, timeout counter, request latch, stall/err.
//    The top level holds the redirect logic and the MEM/WB register.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles -> all outputs 0, req=0, pc_src=00.
//  2. Zero-wait load: ctrl=7'b1100100, addr=0x10, ack same cycle, rdata=0xDEADBEEF
//     -> next cycle RegWrite=1, MemtoReg=1, memData=0xDEADBEEF, no stall.
//  3. 3-wait store: ctrl=7'b0000010, addr=0x20, wdata=0x55, ack on the 4th cycle
//     -> stall high 3 cycles, req/addr/wdata held, a bubble each stall cycle,
//        then stall drops with RegWrite=0.
//  4. Branches: beq zero=1, target=0x40 -> pc_src=01, target=0x40, flush=1.
//     Jump+Branch together, pc_jump=0x80 -> pc_src=10.
//     bne zero=1 -> pc_src=00.
//  5. Timeout: load, no ack for 16 cycles -> mem_err_o=1, bubble, IDLE.
//     A stray ack on the next cycle has no effect.
//  6. Reset mid-WAIT: rst_i on the 2nd wait cycle -> req=0 next cycle, RegWrite stays 0,
//     mem_err_o=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB stage: control-word bit positions, redirect
// encodings and the memory-access FSM state type.
package mips_pkg;

    localparam int CTRL_W        = 7;
    localparam int CB_REG_WRITE  = 6;
    localparam int CB_MEM_TO_REG = 5;
    localparam int CB_BRANCH     = 4;
    localparam int CB_BRANCH_NE  = 3;
    localparam int CB_MEM_READ   = 2;
    localparam int CB_MEM_WRITE  = 1;
    localparam int CB_JUMP       = 0;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic {
        ACC_IDLE,
        ACC_WAIT
    } acc_state_e;

    function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CB_MEM_READ] | ctrl[CB_MEM_WRITE];
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/mem_wb_stage_mem_access_fsm.sv
// Data-memory handshake: issues the request, holds a copy of the op while waiting
// for ack, and abandons the access after ACK_TIMEOUT wait cycles.
//   state    | meaning
//   ACC_IDLE | request (if any) driven from live EX/MEM values
//   ACC_WAIT | request driven from latched copy, pipe stalled until ack or timeout
module mem_access_fsm
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        wb_addr_i,
    input  logic              ack_i,
    output logic              req_o,
    output logic              we_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_o,
    output logic              in_wait_o,
    output logic              err_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [4:0]        wb_addr_o
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    acc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        wb_addr_q;
    logic              capture;
    logic              timeout;

    assign capture = (state_q == ACC_IDLE) && is_mem_op(ctrl_i) && !ack_i;
    assign timeout = (state_q == ACC_WAIT) && !ack_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ACC_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ACC_WAIT && !ack_i) cnt_q <= cnt_q + 1'b1;
            else                               cnt_q <= '0;
            if (timeout) err_q <= 1'b1;
            if (capture) begin
                ctrl_q    <= ctrl_i;
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                wb_addr_q <= wb_addr_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_o     = 1'b0;
        stall_o   = 1'b0;
        ctrl_o    = ctrl_i;
        addr_o    = addr_i;
        wdata_o   = wdata_i;
        wb_addr_o = wb_addr_i;
        case (state_q)
            ACC_IDLE: begin
                req_o   = is_mem_op(ctrl_i);
                stall_o = capture;
                if (capture) state_d = ACC_WAIT;
            end
            ACC_WAIT: begin
                req_o     = 1'b1;
                stall_o   = !ack_i;
                ctrl_o    = ctrl_q;
                addr_o    = addr_q;
                wdata_o   = wdata_q;
                wb_addr_o = wb_addr_q;
                if (ack_i || timeout) state_d = ACC_IDLE;
            end
            default: state_d = ACC_IDLE;
        endcase
        // reset must silence the bus in the very cycle it is asserted
        if (rst_i) begin
            req_o   = 1'b0;
            stall_o = 1'b0;
        end
    end

    assign we_o      = ctrl_o[CB_MEM_WRITE];
    assign in_wait_o = (state_q == ACC_WAIT);
    assign err_o     = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage consumer of the EX/MEM register: branch/jump redirect, data-memory
// access through mem_access_fsm, and the MEM/WB pipeline register.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_signal_i,
    input  logic [DATA_W-1:0] pc_branch_i,
    input  logic [DATA_W-1:0] pc_jump_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] retAlu_i,
    input  logic [DATA_W-1:0] Wridata_i,
    input  logic [4:0]        WBaddr_i,
    mem_wb_stage_if.master    dmem,
    output logic              mem_stall_o,
    output logic [1:0]        pc_src_o,
    output logic [DATA_W-1:0] pc_target_o,
    output logic              flush_o,
    output logic              mem_err_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] memData_o,
    output logic [DATA_W-1:0] aluData_o,
    output logic [4:0]        WBaddr_o
);

    logic              fsm_stall;
    logic              fsm_in_wait;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [DATA_W-1:0] sel_addr;
    logic [4:0]        sel_wb_addr;
    logic              load_ack;
    logic              redirect_en;
    logic              br_taken;

    mem_access_fsm #(
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_mem_access_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ctrl_i    (ctrl_signal_i),
        .addr_i    (retAlu_i),
        .wdata_i   (Wridata_i),
        .wb_addr_i (WBaddr_i),
        .ack_i     (dmem.ack),
        .req_o     (dmem.req),
        .we_o      (dmem.we),
        .addr_o    (sel_addr),
        .wdata_o   (dmem.wdata),
        .stall_o   (fsm_stall),
        .in_wait_o (fsm_in_wait),
        .err_o     (mem_err_o),
        .ctrl_o    (sel_ctrl),
        .wb_addr_o (sel_wb_addr)
    );

    assign dmem.addr   = sel_addr;
    assign mem_stall_o = fsm_stall;

    // the memory address and the ALU result are the same EX/MEM field
    assign load_ack = !fsm_stall && dmem.ack && sel_ctrl[CB_MEM_READ];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            memData_o  <= '0;
            aluData_o  <= '0;
            WBaddr_o   <= '0;
        end else if (fsm_stall) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            aluData_o  <= '0;
            WBaddr_o   <= '0;
        end else begin
            RegWrite_o <= sel_ctrl[CB_REG_WRITE];
            MemtoReg_o <= sel_ctrl[CB_MEM_TO_REG];
            aluData_o  <= sel_addr;
            WBaddr_o   <= sel_wb_addr;
            if (load_ack) memData_o <= dmem.rdata;
        end
    end

    assign redirect_en = !rst_i && !fsm_in_wait && !fsm_stall;
    assign br_taken    = (ctrl_signal_i[CB_BRANCH]    &  zero_i) |
                         (ctrl_signal_i[CB_BRANCH_NE] & ~zero_i);

    always_comb begin
        pc_src_o    = PC_SRC_SEQ;
        pc_target_o = '0;
        if (redirect_en && ctrl_signal_i[CB_JUMP]) begin
            pc_src_o    = PC_SRC_JUMP;
            pc_target_o = pc_jump_i;
        end else if (redirect_en && br_taken) begin
            pc_src_o    = PC_SRC_BRANCH;
            pc_target_o = pc_branch_i;
        end
    end

    assign flush_o = (pc_src_o != PC_SRC_SEQ);

endmodule
